mem16x8_burst_ctrl: RTL and testbench

Initiator/controller for the 16x8 synchronous-write memory. It converts a start/length command plus valid/ready byte streams into the memory's WR/ADDR/DATA_IN/DATA_OUT port. It supports burst fill (write mode) and burst dump (read mode) and absorbs the memory's one-cycle registered read latency. It sits between stream producers/consumers and the memory instance.

---
 rtl/mem16x8_pkg.sv | 10 +
 rtl/MEM16x8.sv | 16 +
 rtl/mem16x8_burst_ctrl.sv | 72 +++++++
 tb/tb_mem16x8_burst_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem16x8_pkg.sv
// mem16x8_pkg: shared widths, modes and controller state type for the 16x8 memory burst controller
package mem16x8_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 5;
    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;
    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_CAP, RD_OUT, FIN} state_t;
endpackage

// File: rtl/MEM16x8.sv
// MEM16x8: 16x8 memory with synchronous write and one-cycle registered read
module MEM16x8
    import mem16x8_pkg::*;
(
    input  logic              CLK,
    input  logic              WR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    always_ff @(posedge CLK) begin
        if (WR) mem_q[ADDR] <= DATA_IN;
        DATA_OUT <= mem_q[ADDR];
    end
endmodule

// File: rtl/mem16x8_burst_ctrl.sv
// mem16x8_burst_ctrl: turns start/length commands and byte streams into burst fills and dumps of MEM16x8
module mem16x8_burst_ctrl
    import mem16x8_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              MODE,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    output logic              DONE,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT
);
    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [LEN_W-1:0]  rem_q, len_d;
    logic [DATA_W-1:0] out_q;

    always_comb len_d = (LEN > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : LEN;

    assign BUSY      = state_q != IDLE;
    assign DONE      = state_q == FIN;
    assign IN_READY  = state_q == WRITE;
    assign OUT_VALID = state_q == RD_OUT;
    assign OUT_DATA  = out_q;
    assign MEM_ADDR  = ptr_q;
    assign MEM_DIN   = IN_DATA;
    // reset blocks the write in its own cycle, even mid-burst
    assign MEM_WR    = (state_q == WRITE) && IN_VALID && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    ptr_q   <= BASE;
                    rem_q   <= len_d;
                    state_q <= (len_d == '0) ? FIN : (MODE == MODE_READ) ? RD_ISSUE : WRITE;
                end
                WRITE: if (IN_VALID) begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                    rem_q <= rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_q <= FIN;
                end
                RD_ISSUE: state_q <= RD_CAP;
                RD_CAP: begin
                    out_q   <= MEM_DOUT;
                    ptr_q   <= ptr_q + ADDR_W'(1);
                    rem_q   <= rem_q - LEN_W'(1);
                    state_q <= RD_OUT;
                end
                // MEM_ADDR already points past the held byte, so the memory prefetches the next one
                RD_OUT: if (OUT_READY) state_q <= (rem_q == '0) ? FIN : RD_CAP;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem16x8_burst_ctrl.sv
// tb_mem16x8_burst_ctrl: controller plus MEM16x8 checked against a transaction-level memory/stream model
module tb_mem16x8_burst_ctrl;
    import mem16x8_pkg::*;

    logic       CLK = 0, RST, START, MODE, IN_VALID, OUT_READY;
    logic [3:0] BASE, MEM_ADDR;
    logic [4:0] LEN;
    logic [7:0] IN_DATA, OUT_DATA, MEM_DIN, MEM_DOUT;
    logic       BUSY, DONE, IN_READY, OUT_VALID, MEM_WR;

    always #5 CLK = ~CLK;

    mem16x8_burst_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .BASE(BASE), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );
    MEM16x8 mem (.CLK(CLK), .WR(MEM_WR), .ADDR(MEM_ADDR), .DATA_IN(MEM_DIN), .DATA_OUT(MEM_DOUT));

    typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
    wr_t        wr_exp[$];
    logic [7:0] rd_exp[$], got[$];
    logic [3:0] wr_log[$];
    int         wr_cyc[$];
    logic [7:0] model_mem[16];
    logic [7:0] wdata[16];
    int         n_cmp = 0, n_bad = 0, done_seen = 0, done_exp = 0, cyc_ctr = 0;
    bit         wr_active = 0, rd_active = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // model side: every write must match the next expected (addr,data); reads must replay model memory
    initial begin : cmp
        wr_t        e;
        bit         hold;
        logic [7:0] hold_d;
        hold = 0;
        forever begin
            @(negedge CLK);
            #1;
            cyc_ctr++;
            if (DONE) done_seen++;
            if (MEM_WR) begin
                wr_log.push_back(MEM_ADDR);
                wr_cyc.push_back(cyc_ctr);
                chk("mem_wr_expected", wr_exp.size() > 0, 1);
                if (wr_exp.size() > 0) begin
                    e = wr_exp.pop_front();
                    chk("wr_addr", MEM_ADDR, e.a);
                    chk("wr_data", MEM_DIN, e.d);
                    model_mem[e.a] = e.d;
                end
            end
            if (!wr_active) chk("in_ready_idle", IN_READY, 0);
            if (!rd_active) chk("out_valid_idle", OUT_VALID, 0);
            if (hold) begin
                chk("hold_valid", OUT_VALID, 1);
                chk("hold_data", OUT_DATA, hold_d);
            end
            hold   = OUT_VALID && !OUT_READY;
            hold_d = OUT_DATA;
            if (OUT_VALID && OUT_READY) begin
                got.push_back(OUT_DATA);
                chk("beat_expected", rd_exp.size() > 0, 1);
                if (rd_exp.size() > 0) chk("rd_data", OUT_DATA, rd_exp.pop_front());
            end
        end
    end

    task automatic finish_cmd(input string nm);
        @(negedge CLK);
        chk({nm, "_done"}, DONE, 1);
        chk({nm, "_done_busy"}, BUSY, 1);
        done_exp++;
        @(negedge CLK);
        chk({nm, "_done_clear"}, DONE, 0);
        chk({nm, "_idle"}, BUSY, 0);
    endtask

    task automatic do_write(input logic [3:0] base, input logic [4:0] len, input int gap_at,
                            input int gap_len, input bit rnd, input bit spam);
        int n = (len > 16) ? 16 : int'(len);
        for (int k = 0; k < n; k++) wr_exp.push_back('{a: base + 4'(k), d: wdata[k]});
        wr_log.delete();
        wr_cyc.delete();
        wr_active = 1;
        START = 1; MODE = MODE_WRITE; BASE = base; LEN = len; IN_VALID = 0;
        tick();
        START = 0;
        for (int k = 0; k < n; k++) begin
            int g = (k == gap_at) ? gap_len : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                IN_VALID = 0;
                IN_DATA  = ~wdata[k];
                if (spam) begin
                    START = 1; MODE = 1'($urandom); BASE = 4'($urandom); LEN = 5'($urandom_range(1, 20));
                end
                @(negedge CLK);
                chk("gap_no_wr", MEM_WR, 0);
                chk("gap_addr", MEM_ADDR, base + 4'(k));
                tick();
                START = 0;
            end
            IN_VALID = 1;
            IN_DATA  = wdata[k];
            tick();
        end
        IN_VALID = 0;
        finish_cmd("wr");
        wr_active = 0;
        chk("wr_queue_drained", wr_exp.size(), 0);
    endtask

    task automatic do_read(input logic [3:0] base, input logic [4:0] len, input int stall_beat,
                           input int stall_len, input bit rnd, input bit timing);
        int n = (len > 16) ? 16 : int'(len);
        int beats = 0, cyc = 0, last = 0, stall_cnt = 0;
        for (int k = 0; k < n; k++) rd_exp.push_back(model_mem[base + 4'(k)]);
        got.delete();
        rd_active = 1;
        START = 1; MODE = MODE_READ; BASE = base; LEN = len;
        OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        START = 0;
        while (beats < n) begin
            @(negedge CLK);
            cyc++;
            if (cyc > 400) begin
                chk("rd_timeout_beats", beats, n);
                break;
            end
            if (OUT_VALID && !OUT_READY) stall_cnt++;
            if (OUT_VALID && OUT_READY) begin
                beats++;
                if (timing && beats == 1) chk("first_valid_latency", cyc, 3);
                if (timing && beats > 1) chk("beat_spacing", cyc - last, 2);
                last = cyc;
            end
            tick();
            OUT_READY = rnd ? 1'($urandom_range(0, 1)) : !(beats == stall_beat && stall_cnt < stall_len);
        end
        OUT_READY = 0;
        finish_cmd("rd");
        rd_active = 0;
        chk("rd_queue_drained", rd_exp.size(), 0);
    endtask

    task automatic chk_got(input string nm, input logic [31:0] exp, input int cnt);
        chk({nm, "_cnt"}, got.size(), cnt);
        for (int i = 0; i < cnt; i++)
            if (i < got.size()) chk(nm, got[i], exp[31-8*i -: 8]);
    endtask

    task automatic set4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) wdata[i] = v[31-8*i -: 8];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1; START = 0; MODE = 0; BASE = 0; LEN = 0; IN_DATA = 0; IN_VALID = 0; OUT_READY = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_mem_wr", MEM_WR, 0);
        chk("rst_out_data", OUT_DATA, 0);
        RST = 0;
        tick();

        set4(32'h11223344);
        do_write(4'd0, 5'd4, -1, 0, 0, 0);
        chk("t1_wr_count", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t1_wr_addr", wr_log[i], i);
            chk("t1_consecutive", wr_cyc[3] - wr_cyc[0], 3);
        end
        do_read(4'd0, 5'd4, -1, 0, 0, 1);
        chk_got("t2_read", 32'h11223344, 4);

        set4(32'hA0A1A2A3);
        do_write(4'd14, 5'd4, -1, 0, 0, 0);
        chk("t3_wr_count", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk("t3_wrap_a0", wr_log[0], 14);
            chk("t3_wrap_a1", wr_log[1], 15);
            chk("t3_wrap_a2", wr_log[2], 0);
            chk("t3_wrap_a3", wr_log[3], 1);
        end
        do_read(4'd14, 5'd4, -1, 0, 0, 1);
        chk_got("t3_read", 32'hA0A1A2A3, 4);

        do_read(4'd0, 5'd3, 1, 5, 0, 0);
        chk_got("t4_stall_read", 32'hA2A33300, 3);
        for (int i = 0; i < 5; i++) wdata[i] = 8'hC0 + 8'(i);
        do_write(4'd4, 5'd5, 2, 3, 0, 0);

        do_write(4'd7, 5'd0, -1, 0, 0, 0);
        chk("t5_len0_no_wr", wr_log.size(), 0);
        for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
        do_write(4'd3, 5'd20, -1, 0, 0, 0);
        chk("t5_len20_count", wr_log.size(), 16);
        do_write(4'd9, 5'd6, 3, 4, 0, 1);
        chk("t5_spam_count", wr_log.size(), 6);
        do_read(4'd9, 5'd0, -1, 0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            logic [3:0] b = 4'($urandom);
            logic [4:0] l = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
                do_write(b, l, -1, 0, 1, 1'($urandom_range(0, 1)));
            end else
                do_read(b, l, -1, 0, 1, 0);
        end

        set4(32'h11223344);
        do_write(4'd0, 5'd4, -1, 0, 0, 0);
        set4(32'h55667788);
        for (int k = 0; k < 4; k++) wr_exp.push_back('{a: 4'(k), d: wdata[k]});
        wr_active = 1;
        START = 1; MODE = MODE_WRITE; BASE = 0; LEN = 4;
        tick();
        START = 0;
        for (int k = 0; k < 2; k++) begin
            IN_VALID = 1; IN_DATA = wdata[k];
            tick();
        end
        IN_DATA = wdata[2]; RST = 1;
        @(negedge CLK);
        chk("t6_rst_mem_wr", MEM_WR, 0);
        tick();
        RST = 0; IN_VALID = 0;
        @(negedge CLK);
        chk("t6_busy", BUSY, 0);
        chk("t6_in_ready", IN_READY, 0);
        chk("t6_done", DONE, 0);
        wr_exp.delete();
        wr_active = 0;
        do_read(4'd0, 5'd4, -1, 0, 0, 0);
        chk_got("t6_read", 32'h55663344, 4);

        repeat (3) @(negedge CLK);
        chk("done_count", done_seen, done_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
